// File: rtl/jtpang_pkg.sv
// jtpang_pkg -- shared definitions for the jtpang object DMA:
// FSM state encoding, default transfer length and address helper.
package jtpang_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_COPY,
        ST_FLUSH,
        ST_REL
    } objdma_state_t;

    localparam int OBJDMA_LEN = 512;
    localparam int RAM_AW     = 12;

    // Source address for a given offset; the 12-bit sum wraps modulo 4096
    function automatic logic [RAM_AW-1:0] wrap_addr(
        input logic [RAM_AW-1:0] base,
        input logic [RAM_AW-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/jtpang_objdma.sv
// jtpang_objdma -- copies LEN bytes of shared CPU RAM into the object
// buffer while holding the Z80 off the bus (busrq_n/busak_n handshake).
// Optional build macro JTPANG_OBJDMA_VBLANK_EN: when defined, a pending
// request only starts while LVBL=0 (inside vertical blank).
module jtpang_objdma
    import jtpang_pkg::*;
#(
    parameter logic [11:0] SRC_BASE = 12'h000,
    parameter int          LEN      = OBJDMA_LEN
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        dma_go,
    input  logic        LVBL,
    input  logic        busak_n,
    output logic        busrq_n,
    output logic [11:0] ram_addr,
    input  logic [7:0]  ram_dout,
    output logic [11:0] buf_addr,
    output logic [7:0]  buf_din,
    output logic        buf_we,
    output logic        busy,
    output logic        done
);

    localparam logic [11:0] LAST = 12'(LEN - 1);

    objdma_state_t r_state;
    logic          r_go_d;
    logic          r_go_pend;
    logic          r_wr;        // data for r_baddr arrives on ram_dout this cycle
    logic          r_busrq_n;
    logic          r_busy;
    logic          r_done;
    logic [11:0]   r_cnt;
    logic [11:0]   r_baddr;

    logic          w_go_rise;
    logic          w_vb_ok;
    logic          w_start;
    logic          w_we;

`ifdef JTPANG_OBJDMA_VBLANK_EN
    assign w_vb_ok = ~LVBL;
`else
    logic w_unused_lvbl;
    assign w_unused_lvbl = LVBL;
    assign w_vb_ok       = 1'b1;
`endif

    assign w_go_rise = dma_go & ~r_go_d;
    assign w_start   = cen & (r_state == ST_IDLE) & r_go_pend & w_vb_ok;
    // A write is lost (not just delayed) if the bus is taken back this cycle
    assign w_we      = cen & r_wr & ~busak_n;

    assign busrq_n  = r_busrq_n;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ram_addr = wrap_addr(SRC_BASE, r_cnt);
    assign buf_addr = r_baddr;
    assign buf_din  = w_we ? ram_dout : 8'h00;
    assign buf_we   = w_we;

    // Capture dma_go rising edges every clk; one pending request is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_go_d    <= 1'b0;
            r_go_pend <= 1'b0;
        end else begin
            r_go_d <= dma_go;
            if (w_go_rise) begin
                r_go_pend <= 1'b1;
            end else if (w_start) begin
                r_go_pend <= 1'b0;
            end
        end
    end

    // Transfer FSM: bus request, address/write pipeline, release and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busrq_n <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr      <= 1'b0;
            r_cnt     <= 12'd0;
            r_baddr   <= 12'd0;
        end else begin
            r_done <= 1'b0;
            if (cen) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state   <= ST_REQ;
                            r_busrq_n <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (!busak_n) begin
                            r_state <= ST_COPY;
                            r_cnt   <= 12'd0;
                            r_wr    <= 1'b0;
                        end
                    end
                    ST_COPY: begin
                        if (busak_n) begin
                            // Bus lost: step back so the dropped byte's address is issued again
                            if (r_wr) begin
                                r_cnt <= r_baddr;
                            end
                            r_wr <= 1'b0;
                        end else begin
                            r_baddr <= r_cnt;
                            r_wr    <= 1'b1;
                            if (r_cnt == LAST) begin
                                r_state <= ST_FLUSH;
                            end else begin
                                r_cnt <= r_cnt + 12'd1;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        // ram_addr still points at the last byte, so a lost write is simply re-armed
                        if (busak_n) begin
                            r_wr <= 1'b0;
                        end else if (r_wr) begin
                            r_wr      <= 1'b0;
                            r_state   <= ST_REL;
                            r_busrq_n <= 1'b1;
                        end else begin
                            r_wr <= 1'b1;
                        end
                    end
                    ST_REL: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= 12'd0;
                        r_baddr <= 12'd0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtpang_objdma.sv
// tb_jtpang_objdma -- directed bench for jtpang_objdma: two instances
// (SRC_BASE 000 and F00), a synchronous RAM model and a Z80 bus model.
module tb_jtpang_objdma;

    logic        clk = 1'b0;
    logic        rst, cen, lvbl;
    logic        go_a, bak_a, rq_a, we_a, busy_a, done_a;
    logic        go_b, bak_b, rq_b, we_b, busy_b, done_b;
    logic [7:0]  dout_a, din_a, dout_b, din_b;
    logic [11:0] addr_a, baddr_a, addr_b, baddr_b;

    always #5 clk = ~clk;

    jtpang_objdma #(.SRC_BASE(12'h000), .LEN(512)) u_dut_a (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(go_a), .LVBL(lvbl),
        .busak_n(bak_a), .busrq_n(rq_a), .ram_addr(addr_a), .ram_dout(dout_a),
        .buf_addr(baddr_a), .buf_din(din_a), .buf_we(we_a), .busy(busy_a), .done(done_a)
    );

    jtpang_objdma #(.SRC_BASE(12'hF00), .LEN(512)) u_dut_b (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(go_b), .LVBL(lvbl),
        .busak_n(bak_b), .busrq_n(rq_b), .ram_addr(addr_b), .ram_dout(dout_b),
        .buf_addr(baddr_b), .buf_din(din_b), .buf_we(we_b), .busy(busy_b), .done(done_b)
    );

    int tests, fails, cyc, go_cyc;
    int go_at1, go_at2, stall_at;
    int wr[2], seqerr[2], daterr[2], addrerr[2], done_cnt[2], fall[2];
    int rise_cyc[2], done_cyc[2], first_done_cyc[2], fall_cyc[2];
    int exp_idx[2], bcnt[2], stall[2];
    logic [11:0] prev_addr[2], src_addr[2];
    logic        prev_rq[2];
    logic [7:0]  bufm[2][512];

    function automatic logic [11:0] base_of(input int i);
        return (i == 0) ? 12'h000 : 12'hF00;
    endfunction

    // RAM contents: instance A holds addr^5A, instance B mixes in the high nibble
    function automatic logic [7:0] ram_fn(input int i, input logic [11:0] a);
        logic [7:0] r;
        if (i == 0) r = a[7:0] ^ 8'h5A;
        else        r = a[7:0] ^ {a[11:8], a[11:8]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input int i);
        wr[i] = 0; seqerr[i] = 0; daterr[i] = 0; addrerr[i] = 0;
        done_cnt[i] = 0; fall[i] = 0; rise_cyc[i] = 0; done_cyc[i] = 0;
        first_done_cyc[i] = 0; fall_cyc[i] = 0; exp_idx[i] = 0;
        for (int k = 0; k < 512; k++) bufm[i][k] = 8'h00;
    endtask

    // RAM answers the address held through the last edge; bus acks 3 clk after request
    task automatic respond(input int i, input logic rq, input logic [11:0] addr,
                           output logic bak, output logic [7:0] dout);
        dout         = ram_fn(i, prev_addr[i]);
        src_addr[i]  = prev_addr[i];
        prev_addr[i] = addr;
        if (rq) begin
            bak     = 1'b1;
            bcnt[i] = 0;
        end else if (stall[i] > 0) begin
            bak      = 1'b1;
            stall[i] = stall[i] - 1;
        end else begin
            if (bcnt[i] < 3) bcnt[i] = bcnt[i] + 1;
            bak = (bcnt[i] >= 3) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic observe(input int i, input logic we, input logic [11:0] ba,
                           input logic [7:0] din, input logic rq, input logic dn);
        logic [11:0] ea;
        if (we) begin
            ea = base_of(i) + 12'(exp_idx[i] % 512);
            if (ba !== 12'(exp_idx[i] % 512)) seqerr[i] = seqerr[i] + 1;
            if (src_addr[i] !== ea) addrerr[i] = addrerr[i] + 1;
            if (din !== ram_fn(i, ea)) daterr[i] = daterr[i] + 1;
            bufm[i][ba[8:0]] = din;
            exp_idx[i] = exp_idx[i] + 1;
            wr[i] = wr[i] + 1;
        end
        if (rq && !prev_rq[i]) rise_cyc[i] = cyc;
        if (!rq && prev_rq[i]) begin
            fall[i] = fall[i] + 1;
            fall_cyc[i] = cyc;
        end
        prev_rq[i] = rq;
        if (dn) begin
            done_cnt[i] = done_cnt[i] + 1;
            done_cyc[i] = cyc;
            if (done_cnt[i] == 1) first_done_cyc[i] = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        go_a = 1'b0;
        go_b = 1'b0;
        if (go_at1 >= 0 && wr[0] == go_at1) begin go_a = 1'b1; go_at1 = -1; end
        if (go_at2 >= 0 && wr[0] == go_at2) begin go_a = 1'b1; go_at2 = -1; end
        if (stall_at >= 0 && wr[0] == stall_at) begin stall[0] = 5; stall_at = -1; end
        respond(0, rq_a, addr_a, bak_a, dout_a);
        respond(1, rq_b, addr_b, bak_b, dout_b);
        #1;
        observe(0, we_a, baddr_a, din_a, rq_a, done_a);
        observe(1, we_b, baddr_b, din_b, rq_b, done_b);
    endtask

    task automatic run_until_done(input int i, input int n, input int budget, input string tag);
        for (int k = 0; k < budget && done_cnt[i] < n; k++) step();
        check(tag, (done_cnt[i] >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; lvbl = 1'b0;
        go_a = 1'b0; go_b = 1'b0; bak_a = 1'b1; bak_b = 1'b1;
        dout_a = 8'h00; dout_b = 8'h00;
        tests = 0; fails = 0; cyc = 0; go_cyc = 0;
        go_at1 = -1; go_at2 = -1; stall_at = -1;
        for (int i = 0; i < 2; i++) begin
            prev_addr[i] = base_of(i); src_addr[i] = base_of(i);
            prev_rq[i] = 1'b1; bcnt[i] = 0; stall[i] = 0;
            clear_stats(i);
        end

        // Reset state
        repeat (3) step();
        check("rst_busrq_n_a", 32'(rq_a), 32'd1);
        check("rst_buf_we_a", 32'(we_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_ram_addr_a", 32'(addr_a), 32'h000);
        check("rst_ram_addr_b", 32'(addr_b), 32'hF00);
        check("rst_buf_addr_a", 32'(baddr_a), 32'd0);
        check("rst_buf_din_a", 32'(din_a), 32'd0);
        check("rst_busrq_n_b", 32'(rq_b), 32'd1);
        rst = 1'b0;
        repeat (2) step();

        // Basic transfer
        clear_stats(0);
        go_a = 1'b1;
        step();
        go_cyc = cyc;
        run_until_done(0, 1, 3000, "t1_done_seen");
        repeat (5) step();
        check("t1_writes", wr[0], 512);
        check("t1_seq_err", seqerr[0], 0);
        check("t1_data_err", daterr[0], 0);
        check("t1_addr_err", addrerr[0], 0);
        check("t1_start_latency", fall_cyc[0], go_cyc + 1);
        check("t1_done_after_rel", done_cyc[0] - rise_cyc[0], 1);
        check("t1_done_pulses", done_cnt[0], 1);
        check("t1_busy_idle", 32'(busy_a), 32'd0);
        check("t1_buf0", 32'(bufm[0][0]), 32'h5A);
        check("t1_buf256", 32'(bufm[0][256]), 32'h5A);
        check("t1_buf511", 32'(bufm[0][511]), 32'hA5);

        // Go pulses during a transfer merge into one extra transfer
        clear_stats(0);
        go_at1 = 100; go_at2 = 200;
        go_a = 1'b1;
        step();
        run_until_done(0, 2, 5000, "t2_two_done");
        repeat (30) step();
        check("t2_done_cnt", done_cnt[0], 2);
        check("t2_transfers", fall[0], 2);
        check("t2_writes", wr[0], 1024);
        check("t2_seq_err", seqerr[0], 0);
        check("t2_data_err", daterr[0], 0);
        check("t2_second_after_rel", (fall_cyc[0] > first_done_cyc[0]) ? 32'd1 : 32'd0, 32'd1);

        // Bus taken back for 5 clk at write 300
        clear_stats(0);
        stall_at = 300;
        go_a = 1'b1;
        step();
        run_until_done(0, 1, 3000, "t3_done_seen");
        check("t3_writes", wr[0], 512);
        check("t3_seq_err", seqerr[0], 0);
        check("t3_data_err", daterr[0], 0);
        check("t3_addr_err", addrerr[0], 0);
        check("t3_buf300", 32'(bufm[0][300]), 32'h76);
        check("t3_buf301", 32'(bufm[0][301]), 32'h77);
        check("t3_buf302", 32'(bufm[0][302]), 32'h74);

        // Reset mid-transfer with a request pending
        clear_stats(0);
        go_at1 = 30;
        go_a = 1'b1;
        step();
        for (int k = 0; k < 2000 && wr[0] < 50; k++) step();
        check("t4_reached_50", wr[0], 50);
        check("t4_busy_mid", 32'(busy_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t4_busrq_async", 32'(rq_a), 32'd1);
        check("t4_busy_async", 32'(busy_a), 32'd0);
        check("t4_we_async", 32'(we_a), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (100) step();
        check("t4_no_more_writes", wr[0], 50);
        check("t4_pend_dropped", fall[0], 1);
        check("t4_busrq_idle", 32'(rq_a), 32'd1);

        // Source window wrapping past 0xFFF
        clear_stats(1);
        go_b = 1'b1;
        step();
        run_until_done(1, 1, 3000, "t5_done_seen");
        check("t5_writes", wr[1], 512);
        check("t5_seq_err", seqerr[1], 0);
        check("t5_addr_err", addrerr[1], 0);
        check("t5_data_err", daterr[1], 0);
        check("t5_buf1", 32'(bufm[1][1]), 32'hFE);
        check("t5_buf255", 32'(bufm[1][255]), 32'h00);
        check("t5_buf257", 32'(bufm[1][257]), 32'h01);
        check("t5_buf511", 32'(bufm[1][511]), 32'hFF);

        // Start with LVBL high
        clear_stats(0);
        lvbl = 1'b1;
        go_a = 1'b1;
        step();
        go_cyc = cyc;
`ifdef JTPANG_OBJDMA_VBLANK_EN
        repeat (40) step();
        check("t6_vb_no_request", fall[0], 0);
        check("t6_vb_busrq_high", 32'(rq_a), 32'd1);
        lvbl = 1'b0;
        run_until_done(0, 1, 3000, "t6_vb_done_seen");
        check("t6_vb_writes", wr[0], 512);
        check("t6_vb_transfers", fall[0], 1);
`else
        run_until_done(0, 1, 3000, "t6_lvbl_ignored_done");
        check("t6_writes", wr[0], 512);
        check("t6_transfers", fall[0], 1);
        check("t6_start_latency", fall_cyc[0], go_cyc + 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
